// File: rtl/rr_stream_mux_if.sv
// Stream bundle between NCH producers, the rr_stream_mux and one consumer.
// RR_STREAM_MUX_LOCK_EN adds the in_last/out_last packet-boundary signals.
interface rr_stream_mux_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NCH   = 4,
   parameter int unsigned SELW  = $clog2(NCH)
);
   logic                   mode;
   logic [SELW-1:0]        sel;
   logic [NCH-1:0]         in_valid;
   logic [NCH*WIDTH-1:0]   in_data;
   logic [NCH-1:0]         in_ready;
   logic                   out_valid;
   logic [WIDTH-1:0]       out_data;
   logic [SELW-1:0]        out_chan;
   logic                   out_ready;
`ifdef RR_STREAM_MUX_LOCK_EN
   logic [NCH-1:0]         in_last;
   logic                   out_last;

   modport master (
      output mode, sel, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_chan, out_last
   );
   modport slave (
      input  mode, sel, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_chan, out_last
   );
`else
   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_chan
   );
   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_chan
   );
`endif
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux, explicit select or round-robin, one-deep output register.
// Optional packet lock (hold grant until in_last) enabled by RR_STREAM_MUX_LOCK_EN.
module rr_stream_mux #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NCH   = 4,
   parameter int unsigned SELW  = $clog2(NCH)
) (
   input  logic           clk,
   input  logic           rst,
   rr_stream_mux_if.slave bus
);
   logic [SELW-1:0] rr_ptr;
   logic [SELW-1:0] scan_idx;
   logic [SELW-1:0] gnt_idx;
   logic            gnt_vld;
   logic            load_en;
   logic            take;
   logic            xfer;
   logic            rr_adv;

`ifdef RR_STREAM_MUX_LOCK_EN
   typedef enum logic {ST_FREE, ST_LOCKED} lock_state_e;
   lock_state_e     state, state_next;
   logic [SELW-1:0] lock_chan, lock_chan_next;
`endif

   // Grant selection: explicit index, locked channel, or first valid from rr_ptr
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      if (!bus.mode) begin
         gnt_vld = (32'(bus.sel) < NCH);
         gnt_idx = bus.sel;
      end
`ifdef RR_STREAM_MUX_LOCK_EN
      else if (state == ST_LOCKED) begin
         gnt_vld = bus.in_valid[lock_chan];
         gnt_idx = lock_chan;
      end
`endif
      else begin
         for (int unsigned k = 0; k < NCH; k++) begin
            scan_idx = SELW'((32'(rr_ptr) + k) % NCH);
            if (!gnt_vld && bus.in_valid[scan_idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = scan_idx;
            end
         end
      end
   end

   // Reset gates ready so nothing is accepted while the register is being cleared
   assign load_en      = !bus.out_valid || bus.out_ready;
   assign take         = gnt_vld && load_en && !rst;
   assign bus.in_ready = take ? (NCH'(1) << gnt_idx) : '0;
   assign xfer         = take && bus.in_valid[gnt_idx];
`ifdef RR_STREAM_MUX_LOCK_EN
   assign rr_adv       = xfer && bus.mode && bus.in_last[gnt_idx];
`else
   assign rr_adv       = xfer && bus.mode;
`endif

   // Output register and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_chan  <= '0;
         rr_ptr        <= '0;
`ifdef RR_STREAM_MUX_LOCK_EN
         bus.out_last  <= 1'b0;
`endif
      end else begin
         if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data[gnt_idx*WIDTH +: WIDTH];
            bus.out_chan  <= gnt_idx;
`ifdef RR_STREAM_MUX_LOCK_EN
            bus.out_last  <= bus.in_last[gnt_idx];
`endif
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         if (rr_adv) begin
            rr_ptr <= (32'(gnt_idx) == NCH - 1) ? '0 : SELW'(gnt_idx + 1'b1);
         end
      end
   end

`ifdef RR_STREAM_MUX_LOCK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FREE;
         lock_chan <= '0;
      end else begin
         state     <= state_next;
         lock_chan <= lock_chan_next;
      end
   end

   // Lock opens on a non-last round-robin beat and closes on the last one
   always_comb begin
      state_next     = state;
      lock_chan_next = lock_chan;
      if (xfer && bus.mode) begin
         if (bus.in_last[gnt_idx]) begin
            state_next = ST_FREE;
         end else begin
            state_next     = ST_LOCKED;
            lock_chan_next = gnt_idx;
         end
      end
   end
`endif
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes and a registered output stage. It is the sequential successor to the fixed 2:1 combinational datapath muxes. It selects among NCH producer streams using either an explicit select or round-robin arbitration, and feeds one consumer. It sits between the TPU operand/result FIFOs and shared downstream units such as the accumulator writeback and the output bus.

Parameters:
WIDTH, 32, data bits per channel
NCH, 4, number of input channels, 2..16
SELW, $clog2(NCH), select/channel-index width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
mode  input  1  0 = explicit select via sel; 1 = round-robin arbitration
sel  input  SELW  channel index used when mode=0
in_valid  input  NCH  per-channel valid
in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_ready  output  NCH  per-channel ready, combinational
out_valid  output  1  output register holds a beat
out_data  output  WIDTH  registered data
out_chan  output  SELW  source channel of the held beat
out_ready  input  1  consumer ready

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_chan=0, rr_ptr=0; lock state cleared. Reset takes priority over any transfer that cycle.
- Output register is one-deep. load_en = !out_valid || out_ready.
- Grant is one-hot, combinational:
  - mode=0: grant[sel] only. If sel >= NCH, there is no grant and no channel is ready.
  - mode=1: first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NCH.
- in_ready[i] = grant[i] && load_en. in_ready does not depend on in_valid when mode=0. When mode=1, in_ready is asserted only for a valid, granted channel.
- Input transfer on channel i: in_valid[i] && in_ready[i]. On the next edge: out_data <= in_data[i], out_chan <= i, out_valid <= 1.
- Output transfer: out_valid && out_ready. If there is no simultaneous input transfer, out_valid <= 0 and out_data/out_chan hold their last values.
- Simultaneous output and input transfers in one cycle give full throughput of one beat per cycle, with no bubble.
- Latency: 1 cycle from input transfer to out_valid.
- rr_ptr updates only on an input transfer while mode=1: rr_ptr <= (i+1) mod NCH, wrapping from NCH-1 to 0. rr_ptr holds its value while mode=0.
- A change of mode or sel takes effect on the grant in the same cycle. A beat already held in the output register is unaffected.
- While out_valid=1 and out_ready=0: all in_ready=0, and out_data/out_chan are stable.
- No data is lost or duplicated under any in_valid/out_ready pattern.

Optional Feature:
Macro RR_STREAM_MUX_LOCK_EN (packet lock).
- Defined:
  - Adds input in_last (NCH) and output out_last (1, registered with out_data, reset 0).
  - When mode=1, after an input transfer with in_last[i]=0, the grant stays locked to channel i until a transfer with in_last[i]=1. Other channels get no ready while locked, even if channel i is idle.
  - rr_ptr advances only on the last beat.
  - When mode=0, in_last is passed through to out_last only; lock has no effect.
  - rst clears the lock.
- Undefined: no in_last/out_last ports; arbitration is per beat.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, all in_ready=0 during reset. After release, mode=1 -> first grant to ch0.
- Explicit select: mode=0, sel=2, in_data[2]=32'hDEADBEEF, in_valid=4'b1111, out_ready=1 -> only in_ready[2]=1; next cycle out_data=32'hDEADBEEF, out_chan=2. Continuous beats arrive 1 per cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3. With in_valid=4'b1010 -> 1,3,1,3.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with new inputs valid -> out_data/out_chan stable, in_ready=0. Raise out_ready -> held beat transfers, and the next beat loads in the same cycle.
- Out-of-range select (NCH=3, SELW=2): mode=0, sel=3 -> in_ready=3'b000, out_valid stays 0.
- Lock (RR_STREAM_MUX_LOCK_EN): mode=1, ch0 sends 3 beats with in_last=0,0,1, ch1 valid throughout -> out_chan=0,0,0,1, out_last=0,0,1,x.
